sound_sequencer: RTL and testbench



---
 rtl/sound_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_sound_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sound_sequencer.sv
// Sound sequencer: queues game sound events by priority and drives a
// square-wave tone generator with timed notes and the three-note goal jingle.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   hit          one-cycle strobe: ball hit paddle
//   wall         one-cycle strobe: ball hit wall
//   goal         one-cycle strobe: goal scored
//   tone_en      tone generator enable (1 = sounding)
//   half_period  half-period in clk cycles for the tone generator
//   note_start   one-cycle pulse at each note start (generator phase restart)
//   busy         high while a note or its trailing gap is in progress
//   active_evt   event being played: 0 none, 1 hit, 2 wall, 3 goal
module sound_sequencer #(
  parameter logic [16:0] HIT_HALF    = 17'd51546,
  parameter logic [16:0] WALL_HALF   = 17'd102459,
  parameter logic [16:0] GOAL_HALF   = 17'd25641,
  parameter logic [23:0] NOTE_CYCLES = 24'd8388608,
  parameter logic [23:0] GAP_CYCLES  = 24'd1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hit,
  input  logic        wall,
  input  logic        goal,
  output logic        tone_en,
  output logic [16:0] half_period,
  output logic        note_start,
  output logic        busy,
  output logic [1:0]  active_evt
);

  localparam int unsigned HALF_W = 17;
  localparam int unsigned CNT_W  = 24;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned EVT_W  = 2;

  localparam logic [EVT_W-1:0] EVT_NONE = EVT_W'(0);
  localparam logic [EVT_W-1:0] EVT_HIT  = EVT_W'(1);
  localparam logic [EVT_W-1:0] EVT_WALL = EVT_W'(2);
  localparam logic [EVT_W-1:0] EVT_GOAL = EVT_W'(3);

  // Last note index of the goal jingle (notes 0, 1, 2).
  localparam logic [IDX_W-1:0] GOAL_LAST_IDX = IDX_W'(2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [EVT_W-1:0]   evt_q, evt_d;
  logic               tone_q, tone_d;
  logic [HALF_W-1:0]  half_q, half_d;
  logic               ns_q, ns_d;
  logic               busy_q, busy_d;
  logic               pend_hit_q, pend_hit_d;
  logic               pend_wall_q, pend_wall_d;
  logic               pend_goal_q, pend_goal_d;

  logic               any_pend;
  logic [EVT_W-1:0]   sel_evt;
  logic               preempt;
  logic               start;
  logic [EVT_W-1:0]   start_evt;

  // Half-period of a given note of a given event.
  function automatic logic [HALF_W-1:0] note_half(input logic [EVT_W-1:0] evt,
                                                  input logic [IDX_W-1:0] idx);
    logic [HALF_W-1:0] h;
    h = '0;
    case (evt)
      EVT_HIT:  h = HIT_HALF;
      EVT_WALL: h = WALL_HALF;
      EVT_GOAL: h = (idx == IDX_W'(1)) ? HIT_HALF : GOAL_HALF;
      default:  h = '0;
    endcase
    return h;
  endfunction

  // Highest-priority pending request: goal > hit > wall.
  always_comb begin
    any_pend = pend_hit_q | pend_wall_q | pend_goal_q;
    sel_evt  = EVT_NONE;
    if (pend_goal_q)      sel_evt = EVT_GOAL;
    else if (pend_hit_q)  sel_evt = EVT_HIT;
    else if (pend_wall_q) sel_evt = EVT_WALL;
  end

  // A pending goal cuts short a hit or wall note (or its gap); goals are never cut.
  assign preempt = (state_q != S_IDLE) && pend_goal_q &&
                   ((evt_q == EVT_HIT) || (evt_q == EVT_WALL));

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    evt_d     = evt_q;
    tone_d    = tone_q;
    half_d    = half_q;
    ns_d      = 1'b0;
    busy_d    = busy_q;
    start     = 1'b0;
    start_evt = sel_evt;

    case (state_q)
      S_IDLE: begin
        if (any_pend) start = 1'b1;
      end
      S_PLAY: begin
        if (preempt) begin
          start     = 1'b1;
          start_evt = EVT_GOAL;
        end else if (cnt_q == '0) begin
          state_d = S_GAP;
          tone_d  = 1'b0;
          cnt_d   = GAP_CYCLES - CNT_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (preempt) begin
          start     = 1'b1;
          start_evt = EVT_GOAL;
        end else if (cnt_q == '0) begin
          if ((evt_q == EVT_GOAL) && (idx_q < GOAL_LAST_IDX)) begin
            // Next note of the goal jingle.
            state_d = S_PLAY;
            idx_d   = idx_q + IDX_W'(1);
            tone_d  = 1'b1;
            ns_d    = 1'b1;
            half_d  = note_half(EVT_GOAL, idx_q + IDX_W'(1));
            cnt_d   = NOTE_CYCLES - CNT_W'(1);
          end else if (any_pend) begin
            start = 1'b1;
          end else begin
            state_d = S_IDLE;
            evt_d   = EVT_NONE;
            busy_d  = 1'b0;
            half_d  = '0;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (start) begin
      state_d = S_PLAY;
      evt_d   = start_evt;
      idx_d   = '0;
      tone_d  = 1'b1;
      ns_d    = 1'b1;
      busy_d  = 1'b1;
      half_d  = note_half(start_evt, IDX_W'(0));
      cnt_d   = NOTE_CYCLES - CNT_W'(1);
    end

    // A strobe on the start edge wins over the clear, so that event replays once.
    pend_hit_d  = (pend_hit_q  & ~(start && (start_evt == EVT_HIT)))  | hit;
    pend_wall_d = (pend_wall_q & ~(start && (start_evt == EVT_WALL))) | wall;
    pend_goal_d = (pend_goal_q & ~(start && (start_evt == EVT_GOAL))) | goal;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      evt_q       <= EVT_NONE;
      tone_q      <= 1'b0;
      half_q      <= '0;
      ns_q        <= 1'b0;
      busy_q      <= 1'b0;
      pend_hit_q  <= 1'b0;
      pend_wall_q <= 1'b0;
      pend_goal_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      evt_q       <= evt_d;
      tone_q      <= tone_d;
      half_q      <= half_d;
      ns_q        <= ns_d;
      busy_q      <= busy_d;
      pend_hit_q  <= pend_hit_d;
      pend_wall_q <= pend_wall_d;
      pend_goal_q <= pend_goal_d;
    end
  end

  assign tone_en     = tone_q;
  assign half_period = half_q;
  assign note_start  = ns_q;
  assign busy        = busy_q;
  assign active_evt  = evt_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer: directed scenarios followed by random strobes,
// compared cycle by cycle against a timeline model of the expected outputs.
module tb_sound_sequencer;

  localparam int NOTE = 16;
  localparam int GAP  = 4;
  localparam int H_HIT  = 51546;
  localparam int H_WALL = 102459;
  localparam int H_GOAL = 25641;

  logic        clk = 1'b0;
  logic        rst;
  logic        hit, wall, goal;
  logic        tone_en;
  logic [16:0] half_period;
  logic        note_start;
  logic        busy;
  logic [1:0]  active_evt;

  int n_checks = 0;
  int n_errors = 0;

  sound_sequencer #(
    .HIT_HALF   (17'd51546),
    .WALL_HALF  (17'd102459),
    .GOAL_HALF  (17'd25641),
    .NOTE_CYCLES(24'd16),
    .GAP_CYCLES (24'd4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hit        (hit),
    .wall       (wall),
    .goal       (goal),
    .tone_en    (tone_en),
    .half_period(half_period),
    .note_start (note_start),
    .busy       (busy),
    .active_evt (active_evt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Model: expected outputs per cycle. The current event is expanded into a
  // list of future cycles when it starts; pending requests are plain flags.
  typedef struct {
    bit tone;
    int half;
    bit ns;
    bit busy;
    int evt;
  } out_t;

  out_t cur;
  out_t tl[$];
  bit   p_hit, p_wall, p_goal;

  function automatic out_t idle_out();
    out_t o;
    o.tone = 0; o.half = 0; o.ns = 0; o.busy = 0; o.evt = 0;
    return o;
  endfunction

  task automatic model_reset();
    tl.delete();
    cur    = idle_out();
    p_hit  = 0;
    p_wall = 0;
    p_goal = 0;
  endtask

  task automatic model_start(input int e);
    int   n;
    int   h;
    out_t o;
    tl.delete();
    n = (e == 3) ? 3 : 1;
    for (int k = 0; k < n; k++) begin
      if (e == 1)      h = H_HIT;
      else if (e == 2) h = H_WALL;
      else             h = (k == 1) ? H_HIT : H_GOAL;
      for (int c = 0; c < NOTE; c++) begin
        o.tone = 1; o.half = h; o.ns = (c == 0); o.busy = 1; o.evt = e;
        tl.push_back(o);
      end
      for (int c = 0; c < GAP; c++) begin
        o.tone = 0; o.half = h; o.ns = 0; o.busy = 1; o.evt = e;
        tl.push_back(o);
      end
    end
    cur = tl.pop_front();
    if (e == 1) p_hit = 0;
    if (e == 2) p_wall = 0;
    if (e == 3) p_goal = 0;
  endtask

  // One active clock edge with the strobes sampled at that edge.
  task automatic model_edge(input bit h, input bit w, input bit g);
    if (cur.busy && cur.evt != 3 && p_goal) model_start(3);
    else if (tl.size() > 0)                 cur = tl.pop_front();
    else if (p_goal)                        model_start(3);
    else if (p_hit)                         model_start(1);
    else if (p_wall)                        model_start(2);
    else                                    cur = idle_out();
    p_hit  = p_hit  | h;
    p_wall = p_wall | w;
    p_goal = p_goal | g;
  endtask

  task automatic compare_all();
    check("tone_en",    int'(tone_en),    int'(cur.tone));
    check("note_start", int'(note_start), int'(cur.ns));
    check("busy",       int'(busy),       int'(cur.busy));
    check("active_evt", int'(active_evt), cur.evt);
    if (cur.busy) check("half_period", int'(half_period), cur.half);
  endtask

  // Drive strobes for the next edge, take the edge, then compare.
  task automatic step(input bit h, input bit w, input bit g);
    hit  = h;
    wall = w;
    goal = g;
    @(posedge clk);
    model_edge(h, w, g);
    #1;
    compare_all();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  // Reset pulse between clock edges; strobes held during reset must not stick.
  task automatic reset_mid_cycle();
    #3;
    rst = 1'b1;
    #1;
    check("rst_tone_en",    int'(tone_en),     0);
    check("rst_busy",       int'(busy),        0);
    check("rst_half",       int'(half_period), 0);
    check("rst_note_start", int'(note_start),  0);
    check("rst_active_evt", int'(active_evt),  0);
    hit = 1; wall = 1; goal = 1;
    @(posedge clk);
    @(posedge clk);
    #2;
    hit = 0; wall = 0; goal = 0;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst  = 1'b1;
    hit  = 0;
    wall = 0;
    goal = 0;
    model_reset();
    #12;
    check("reset_tone_en",    int'(tone_en),     0);
    check("reset_half",       int'(half_period), 0);
    check("reset_note_start", int'(note_start),  0);
    check("reset_busy",       int'(busy),        0);
    check("reset_active_evt", int'(active_evt),  0);
    rst = 1'b0;

    // Single hit note.
    idle_steps(9);
    step(1, 0, 0);
    idle_steps(30);
    // Hit and wall together: hit, gap, wall.
    step(1, 1, 0);
    idle_steps(50);
    // Goal jingle.
    step(0, 0, 1);
    idle_steps(70);
    // Goal preempts a wall note at its fifth cycle.
    step(0, 1, 0);
    idle_steps(5);
    step(0, 0, 1);
    idle_steps(70);
    // Repeated hits collapse; one on the start edge replays once.
    step(1, 0, 0);
    step(1, 0, 0);
    idle_steps(3);
    step(1, 0, 0);
    idle_steps(4);
    step(1, 0, 0);
    idle_steps(60);
    // Goal during a goal jingle plays it twice.
    step(0, 0, 1);
    idle_steps(10);
    step(0, 0, 1);
    idle_steps(140);
    // Reset mid-note with a wall pending.
    step(1, 0, 0);
    idle_steps(3);
    step(0, 1, 0);
    idle_steps(2);
    reset_mid_cycle();
    idle_steps(30);

    // Random strobes with occasional mid-note resets.
    for (int i = 0; i < 2500; i++) begin
      step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 2);
      if ((i % 500) == 499 && cur.busy) reset_mid_cycle();
    end
    idle_steps(150);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
